dff_pipe: RTL

Parametrised multi-stage register pipeline with a valid/ready handshake. It generalises the single D flip-flop to WIDTH bits and DEPTH stages. Empty stages absorb bubbles, so a stall does not cost throughput. It carries datapath words between timing-critical blocks and provides a synchronous flush and an occupancy count.

---
 rtl/dff_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage WIDTH-bit register pipeline with valid/ready handshake,
// bubble collapse, synchronous flush and occupancy count. Macro DFF_PIPE_CLR_DATA_EN adds data reset.
module dff_pipe #(
    parameter int unsigned             WIDTH     = 8,
    parameter int unsigned             DEPTH     = 4,
    parameter logic [WIDTH-1:0]        RESET_VAL = {WIDTH{1'b0}},
    localparam int unsigned            OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] rdy_s;
    logic [DEPTH:0]   src_valid_s;
    logic [WIDTH-1:0] src_data_s [DEPTH+1];
    logic [OCC_W-1:0] occ_s;

    // Ready chain: a stage is ready when it or any stage after it is empty, or the sink accepts.
    always_comb begin
        logic acc;
        acc   = out_ready;
        rdy_s = {DEPTH{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc      = acc | ~valid_q[i];
            rdy_s[i] = acc;
        end
    end

    // Source of each stage: the upstream port for stage 0, the previous stage otherwise.
    always_comb begin
        src_valid_s   = {valid_q, in_valid};
        src_data_s[0] = in_data;
        for (int i = 0; i < DEPTH; i++) begin
            src_data_s[i+1] = data_q[i];
        end
    end

    // Next state: flush clears every valid but leaves data untouched; data loads only with a valid source.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (rdy_s[i]) begin
                valid_d[i] = src_valid_s[i];
                if (src_valid_s[i]) begin
                    data_d[i] = src_data_s[i];
                end else begin
                    data_d[i] = data_q[i];
                end
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
    end

    // Occupancy is the population count of the registered valid bits.
    always_comb begin
        occ_s = {OCC_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            occ_s = occ_s + OCC_W'(valid_q[i]);
        end
    end

    // Valid bit register; reset has priority over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= {DEPTH{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

`ifdef DFF_PIPE_CLR_DATA_EN
    // Data registers with reset to RESET_VAL.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else begin
            data_q <= data_d;
        end
    end
`else
    // Data registers without reset; contents are don't-care while their valid is low.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
`endif

    assign in_ready  = rdy_s[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_s;

endmodule
